// File: rtl/scan_chain_pkg.sv
// Shared types and width helpers for the scan chain controller and its shift unit.
package scan_chain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IN,
    ST_SHIFT,
    ST_OUT,
    ST_DONE
  } state_t;

  function automatic int bit_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int chunk_cnt_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/scan_chain_controller_if.sv
// Host chunk streams: in_* carries chunks toward the chain, out_* returns captured chunks.
interface scan_chain_controller_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/scan_shift_unit.sv
// WIDTH-bit load/shift/capture register: drives bit 0 out first, captures the chain
// output into the MSB so the first emerging bit ends up in bit 0. Needs WIDTH >= 2.
module scan_shift_unit
  import scan_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_scan_out,
  output logic             o_last_bit,
  output logic             o_scan_in,
  output logic [WIDTH-1:0] o_data
);

  localparam int BCW = bit_cnt_w(WIDTH);

  logic [WIDTH-1:0] r_shreg;
  logic [BCW-1:0]   r_bit_cnt;
  logic             w_last_bit;

  assign w_last_bit = (r_bit_cnt == BCW'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (i_load) begin
      r_shreg   <= i_load_data;
      r_bit_cnt <= '0;
    end else if (i_shift) begin
      // scan_out is taken before the chain moves, so it is the bit currently at the tail
      r_shreg   <= {i_scan_out, r_shreg[WIDTH-1:1]};
      r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BCW'(1);
    end
  end

  assign o_last_bit = w_last_bit;
  assign o_scan_in  = r_shreg[0];
  assign o_data     = r_shreg;

endmodule

// File: rtl/scan_chain_controller.sv
// Host-side scan chain controller: streams WIDTH-bit chunks into the CSR chain, returns the
// displaced bits as chunks, and stalls the processor for the duration of a transaction.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_IDLE    | no transaction; processor_enable follows run
//   ST_WAIT_IN | in_ready high, waiting for the next host chunk
//   ST_SHIFT   | scan_enable high, one chain bit per cycle for WIDTH cycles
//   ST_OUT     | out_valid high, holding the captured chunk until accepted
//   ST_DONE    | single-cycle done pulse, then back to ST_IDLE
module scan_chain_controller
  import scan_chain_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_run,
  scan_chain_controller_if.slave  host,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_scan_enable,
  output logic                    o_scan_in,
  input  logic                    i_scan_out,
  output logic                    o_processor_enable
);

  localparam int CCW = chunk_cnt_w(NUM_REGS);

  state_t           r_state;
  logic [CCW-1:0]   r_chunk_cnt;
  logic             r_proc_en;

  logic             w_load;
  logic             w_shift;
  logic             w_last_bit;
  logic             w_last_chunk;
  logic             w_scan_in;
  logic [WIDTH-1:0] w_data;

  assign w_load       = (r_state == ST_WAIT_IN) && host.in_valid;
  assign w_shift      = (r_state == ST_SHIFT);
  assign w_last_chunk = (r_chunk_cnt == CCW'(NUM_REGS - 1));

  scan_shift_unit #(
    .WIDTH(WIDTH)
  ) u_shift (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_load_data (host.in_data),
    .i_shift     (w_shift),
    .i_scan_out  (i_scan_out),
    .o_last_bit  (w_last_bit),
    .o_scan_in   (w_scan_in),
    .o_data      (w_data)
  );

  // processor_enable is loaded with run only on edges whose next state is ST_IDLE
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= ST_IDLE;
      r_chunk_cnt <= '0;
      r_proc_en   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state     <= ST_WAIT_IN;
            r_chunk_cnt <= '0;
            r_proc_en   <= 1'b0;
          end else begin
            r_proc_en   <= i_run;
          end
        end
        ST_WAIT_IN: begin
          r_proc_en <= 1'b0;
          if (host.in_valid) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_proc_en <= 1'b0;
          if (w_last_bit) r_state <= ST_OUT;
        end
        ST_OUT: begin
          r_proc_en <= 1'b0;
          if (host.out_ready) begin
            if (w_last_chunk) begin
              r_state <= ST_DONE;
            end else begin
              r_chunk_cnt <= r_chunk_cnt + CCW'(1);
              r_state     <= ST_WAIT_IN;
            end
          end
        end
        ST_DONE: begin
          r_state   <= ST_IDLE;
          r_proc_en <= i_run;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_proc_en <= 1'b0;
        end
      endcase
    end
  end

  assign host.in_ready      = (r_state == ST_WAIT_IN);
  assign host.out_valid     = (r_state == ST_OUT);
  assign host.out_data      = w_data;
  assign o_busy             = (r_state != ST_IDLE);
  assign o_done             = (r_state == ST_DONE);
  assign o_scan_enable      = (r_state == ST_SHIFT);
  assign o_scan_in          = w_scan_in;
  assign o_processor_enable = r_proc_en;

endmodule

// File: tb/tb_scan_chain_controller.sv
// Scoreboard bench: a CSR chain model hangs off the scan pins, a bit-queue reference model
// predicts returned chunks, and a monitor compares every accepted out_data against it.
module tb_scan_chain_controller;

  localparam int W        = 8;
  localparam int N        = 8;
  localparam int CHAIN    = W * N;
  // edges from the edge that samples start to the edge that enters the done cycle
  localparam int DONE_LAT = N * (W + 2);

  typedef logic [W-1:0] chunk_arr_t [N];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic run = 1'b0;
  logic busy, done, scan_enable, scan_in, scan_out, proc_en;

  scan_chain_controller_if #(.WIDTH(W)) u_if ();

  scan_chain_controller #(
    .WIDTH   (W),
    .NUM_REGS(N)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_start            (start),
    .i_run              (run),
    .host               (u_if.slave),
    .o_busy             (busy),
    .o_done             (done),
    .o_scan_enable      (scan_enable),
    .o_scan_in          (scan_in),
    .i_scan_out         (scan_out),
    .o_processor_enable (proc_en)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t_start  = 0;
  int done_cnt = 0;
  int out_stall = 0;
  int out_wait  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // CSR chain: scan_out is the tail bit, new bits enter at the head
  logic [CHAIN-1:0] chain;
  logic [CHAIN-1:0] chain_init;
  logic             load_chain = 1'b1;
  assign scan_out = chain[0];
  always @(posedge clk) begin
    if (load_chain)       chain <= chain_init;
    else if (scan_enable) chain <= {scan_in, chain[CHAIN-1:1]};
  end

  // reference: the chain as a FIFO of bits, front = next to emerge
  bit         mq[$];
  bit [W-1:0] exp_q[$];
  bit [W-1:0] rx_q[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic model_accept(input logic [W-1:0] d);
    bit [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) v[i] = mq.pop_front();
    for (int i = 0; i < W; i++) mq.push_back(d[i]);
    exp_q.push_back(v);
  endtask

  task automatic model_partial(input logic [W-1:0] d, input int nbits);
    bit b;
    for (int i = 0; i < nbits; i++) b = mq.pop_front();
    for (int i = 0; i < nbits; i++) mq.push_back(d[i]);
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_scan_enable"}, scan_enable, 1'b0);
    chk1({tag, "_scan_in"}, scan_in, 1'b0);
    chk1({tag, "_in_ready"}, u_if.in_ready, 1'b0);
    chk1({tag, "_out_valid"}, u_if.out_valid, 1'b0);
    chkw({tag, "_out_data"}, int'(u_if.out_data), 0);
    chk1({tag, "_proc_en"}, proc_en, 1'b0);
  endtask

  // host side of the return stream, optionally withholding out_ready
  initial begin
    u_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (u_if.out_valid) begin
        if (out_wait < out_stall) begin
          u_if.out_ready = 1'b0;
          out_wait++;
        end else begin
          u_if.out_ready = 1'b1;
        end
      end else begin
        u_if.out_ready = 1'b1;
        out_wait = 0;
      end
    end
  end

  // output monitor / scoreboard
  logic         held = 1'b0;
  logic [W-1:0] held_data;
  always @(negedge clk) begin
    if (rst) begin
      if (u_if.out_valid && !u_if.out_ready) begin
        if (held) chkw("out_data_stable", int'(u_if.out_data), int'(held_data));
        else begin
          held      = 1'b1;
          held_data = u_if.out_data;
        end
      end else if (u_if.out_valid && u_if.out_ready) begin
        if (held) chkw("out_data_stable", int'(u_if.out_data), int'(held_data));
        held = 1'b0;
        rx_q.push_back(u_if.out_data);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual=%0h required=none t=%0t", u_if.out_data, $time);
        end else begin
          chkw("out_data", int'(u_if.out_data), int'(exp_q.pop_front()));
        end
      end else begin
        held = 1'b0;
      end
    end else begin
      held = 1'b0;
    end
  end

  always @(negedge clk) if (rst && done) done_cnt++;

  // processor_enable in any cycle = run at the previous edge, unless a transaction is open
  logic run_prev = 1'b0;
  logic rst_prev = 1'b0;
  always @(posedge clk) begin
    run_prev <= run;
    rst_prev <= rst;
  end
  always @(negedge clk) if (rst && rst_prev) chk1("proc_en_rule", proc_en, run_prev && !busy);

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk1("start_from_idle", busy, 1'b0);
    t_start = cyc + 1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_in_ready(input string name);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (u_if.in_ready) return;
    end
    timeout_fail(name);
  endtask

  task automatic send_chunk(input logic [W-1:0] d, input int stall, input bit start_in_shift);
    if (stall > 0) begin
      u_if.in_valid = 1'b0;
      wait_in_ready("in_ready_wait_stall");
      for (int j = 0; j < stall; j++) begin
        if (j > 0) @(negedge clk);
        chk1("stall_scan_enable", scan_enable, 1'b0);
        chk1("stall_in_ready", u_if.in_ready, 1'b1);
      end
      @(posedge clk);
      #1;
    end
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    wait_in_ready("in_ready_wait");
    model_accept(d);
    @(posedge clk);
    #1;
    if (start_in_shift) begin
      start = 1'b1;
      chk1("start_pulse_in_shift", scan_enable, 1'b1);
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic run_txn(input chunk_arr_t data, input int in_stall, input int o_stall,
                         input bit start_busy, input bit check_lat);
    int  d0;
    bit  seen;
    out_stall = o_stall;
    d0 = done_cnt;
    rx_q.delete();
    do_start();
    for (int i = 0; i < N; i++) send_chunk(data[i], in_stall, start_busy && (i == 2));
    u_if.in_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) timeout_fail("done_wait");
    if (check_lat) chkw("done_latency", cyc - t_start, DONE_LAT);
    if (start_busy) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk1("idle_after_done", busy, 1'b0);
    chk1("proc_en_reentry", proc_en, run);
    repeat (3) @(negedge clk);
    chkw("done_count", done_cnt - d0, 1);
    chkw("rx_count", rx_q.size(), N);
  endtask

  chunk_arr_t dat;
  logic [W-1:0] pd;

  initial begin
    u_if.in_valid = 1'b0;
    u_if.in_data  = '0;
    for (int i = 0; i < CHAIN; i++) begin
      chain_init[i] = 1'($urandom_range(0, 1));
      mq.push_back(chain_init[i]);
    end
    repeat (3) @(posedge clk);
    #1 load_chain = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b1;
    run = 1'b1;
    repeat (2) @(negedge clk);
    chk1("proc_en_idle_run", proc_en, 1'b1);

    // round trip: load 1..8, then read them back with zeros
    for (int i = 0; i < N; i++) dat[i] = W'(i + 1);
    run_txn(dat, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) dat[i] = '0;
    run_txn(dat, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) chkw("roundtrip_const", int'(rx_q[i]), i + 1);

    // stalls on both sides, processor held off
    @(posedge clk);
    #1 run = 1'b0;
    for (int i = 0; i < N; i++) dat[i] = W'($urandom);
    run_txn(dat, 5, 3, 1'b0, 1'b0);

    // start pulses during SHIFT and DONE must be ignored
    @(posedge clk);
    #1 run = 1'b1;
    for (int i = 0; i < N; i++) dat[i] = W'($urandom);
    run_txn(dat, 0, 0, 1'b1, 1'b1);

    // asynchronous reset after 3 of 8 shifts of the first chunk
    do_start();
    pd = W'($urandom);
    u_if.in_valid = 1'b1;
    u_if.in_data  = pd;
    wait_in_ready("in_ready_wait_rst");
    model_partial(pd, 3);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    chk1("pre_reset_scan_enable", scan_enable, 1'b1);
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    u_if.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // random stalls and run after the partial shift
    run = 1'($urandom_range(0, 1));
    for (int i = 0; i < N; i++) dat[i] = W'($urandom);
    run_txn(dat, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 1'b0);
    @(posedge clk);
    #1 run = 1'b1;
    for (int i = 0; i < N; i++) dat[i] = W'($urandom);
    run_txn(dat, 0, 0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
